// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types for the universal shift register: operation
//               mode encoding and the run-control FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Operation codes as seen on mode_i; codes 6 and 7 are reserved and
  // behave as SM_HOLD.
  typedef enum logic [2:0] {
    SM_HOLD = 3'd0,
    SM_SHL  = 3'd1,
    SM_SHR  = 3'd2,
    SM_SAR  = 3'd3,
    SM_ROL  = 3'd4,
    SM_ROR  = 3'd5
  } shift_mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } shift_state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_step_unit
// Description : Combinational single-step shifter. Moves data_i by STEP bits
//               according to mode_i and produces the candidate next value.
// Ports       : mode_i   [2:0]    operation code (6/7 treated as hold)
//               data_i   [N-1:0]  current register contents
//               fill_l_i [STEP-1:0] bits entering at the MSB side (SHR)
//               fill_r_i [STEP-1:0] bits entering at the LSB side (SHL)
//               next_o   [N-1:0]  shifted result
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic [2:0]      mode_i,
  input  logic [N-1:0]    data_i,
  input  logic [STEP-1:0] fill_l_i,
  input  logic [STEP-1:0] fill_r_i,
  output logic [N-1:0]    next_o
);

  always_comb begin
    next_o = data_i;
    case (mode_i)
      SM_SHL:  next_o = {data_i[N-STEP-1:0], fill_r_i};
      SM_SHR:  next_o = {fill_l_i, data_i[N-1:STEP]};
      // Arithmetic right shift replicates the sign bit into the vacated MSBs.
      SM_SAR:  next_o = {{STEP{data_i[N-1]}}, data_i[N-1:STEP]};
      SM_ROL:  next_o = {data_i[N-STEP-1:0], data_i[N-1 -: STEP]};
      SM_ROR:  next_o = {data_i[STEP-1:0], data_i[N-1:STEP]};
      default: next_o = data_i;
    endcase
  end

endmodule : shift_step_unit
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal register with parallel load and counted multi-cycle
//               shift/rotate runs (STEP bits per cycle), start/busy/done
//               handshake and abort.
// Ports       : clk_i       clock, rising edge
//               rst_ni      asynchronous active-low reset
//               mode_i      operation, sampled with start_i
//               start_i     start a counted run (idle only)
//               count_i     shift cycles for the run, sampled with start_i
//               load_i      parallel load (idle only, wins over start_i)
//               abort_i     terminate an active run without done_o
//               parallel_i  parallel load data
//               serial_l_i  fill bits entering at the MSB side
//               serial_r_i  fill bits entering at the LSB side
//               parallel_o  register contents
//               serial_l_o  top STEP bits of the register
//               serial_r_o  bottom STEP bits of the register
//               busy_o      run in progress
//               done_o      one-cycle pulse after a completed run
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int CW   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [2:0]      mode_i,
  input  logic            start_i,
  input  logic [CW-1:0]   count_i,
  input  logic            load_i,
  input  logic            abort_i,
  input  logic [N-1:0]    parallel_i,
  input  logic [STEP-1:0] serial_l_i,
  input  logic [STEP-1:0] serial_r_i,
  output logic [N-1:0]    parallel_o,
  output logic [STEP-1:0] serial_l_o,
  output logic [STEP-1:0] serial_r_o,
  output logic            busy_o,
  output logic            done_o
);

  shift_state_e  state_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  data_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    mode_q;
  logic          busy_q;
  logic          done_q;

  // Candidate value for a shift edge; serial fills are taken live each cycle.
  shift_step_unit #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .mode_i   (mode_q),
    .data_i   (data_q),
    .fill_l_i (serial_l_i),
    .fill_r_i (serial_r_i),
    .next_o   (data_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            data_q <= parallel_i;
          end else if (start_i) begin
            mode_q <= mode_i;
            cnt_q  <= count_i;
            if (count_i != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              // Zero-length run completes immediately.
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            data_q <= data_d;
            cnt_q  <= cnt_q - CW'(1);
            // This edge performs the last shift of the run.
            if (cnt_q == CW'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign parallel_o = data_q;
  assign serial_l_o = data_q[N-1 -: STEP];
  assign serial_r_o = data_q[STEP-1:0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Directed self-checking bench for univ_shift_reg, with one
//               N=8/STEP=1 instance and one N=8/STEP=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;

  // STEP=1 instance signals
  logic [2:0] mode;
  logic       start;
  logic [3:0] count;
  logic       load;
  logic       abort;
  logic [7:0] par_in;
  logic       sl_in;
  logic       sr_in;
  logic [7:0] par_out;
  logic       sl_out;
  logic       sr_out;
  logic       busy;
  logic       done;

  // STEP=4 instance signals
  logic [2:0] mode4;
  logic       start4;
  logic [3:0] count4;
  logic       load4;
  logic [7:0] par_in4;
  logic [7:0] par_out4;
  logic [3:0] sl_out4;
  logic [3:0] sr_out4;
  logic       busy4;
  logic       done4;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.N(8), .STEP(1), .CW(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode),
    .start_i    (start),
    .count_i    (count),
    .load_i     (load),
    .abort_i    (abort),
    .parallel_i (par_in),
    .serial_l_i (sl_in),
    .serial_r_i (sr_in),
    .parallel_o (par_out),
    .serial_l_o (sl_out),
    .serial_r_o (sr_out),
    .busy_o     (busy),
    .done_o     (done)
  );

  univ_shift_reg #(.N(8), .STEP(4), .CW(4)) dut4 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode4),
    .start_i    (start4),
    .count_i    (count4),
    .load_i     (load4),
    .abort_i    (1'b0),
    .parallel_i (par_in4),
    .serial_l_i (4'h0),
    .serial_r_i (4'h0),
    .parallel_o (par_out4),
    .serial_l_o (sl_out4),
    .serial_r_o (sr_out4),
    .busy_o     (busy4),
    .done_o     (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] po, input logic b, input logic d);
    chk({tag, ".po"},   32'(par_out), 32'(po));
    chk({tag, ".busy"}, 32'(busy),    32'(b));
    chk({tag, ".done"}, 32'(done),    32'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 3'd0; start = 1'b0; count = 4'd0; load = 1'b0; abort = 1'b0;
    par_in = 8'h00; sl_in = 1'b0; sr_in = 1'b0;
    mode4 = 3'd0; start4 = 1'b0; count4 = 4'd0; load4 = 1'b0; par_in4 = 8'h00;
    tick(); tick();
    chk_state("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.sl", 32'(sl_out), 32'd0);
    chk("reset.sr", 32'(sr_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Parallel load
    load = 1'b1; par_in = 8'hA5; tick(); load = 1'b0;
    chk_state("load_a5", 8'hA5, 1'b0, 1'b0);

    // SHL run; load while busy must be ignored
    mode = 3'd1; count = 4'd3; start = 1'b1; sr_in = 1'b0; tick(); start = 1'b0;
    chk_state("shl_start", 8'hA5, 1'b1, 1'b0);
    load = 1'b1; par_in = 8'h00; tick(); load = 1'b0;
    chk_state("load_busy", 8'h4A, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle and mid-run
    #2 rst_n = 1'b0;
    #1 chk_state("async_rst", 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    chk_state("after_rst", 8'h00, 1'b0, 1'b0);

    // ROL C=3 on 0x81
    load = 1'b1; par_in = 8'h81; tick(); load = 1'b0;
    mode = 3'd4; count = 4'd3; start = 1'b1; tick(); start = 1'b0;
    chk_state("rol_c0", 8'h81, 1'b1, 1'b0);
    tick(); chk_state("rol_c1", 8'h03, 1'b1, 1'b0);
    tick(); chk_state("rol_c2", 8'h06, 1'b1, 1'b0);
    tick(); chk_state("rol_c3", 8'h0C, 1'b0, 1'b1);
    tick(); chk_state("rol_end", 8'h0C, 1'b0, 1'b0);

    // SAR C=2 on 0x90
    load = 1'b1; par_in = 8'h90; tick(); load = 1'b0;
    mode = 3'd3; count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    tick(); chk_state("sar_c1", 8'hC8, 1'b1, 1'b0);
    tick(); chk_state("sar_c2", 8'hE4, 1'b0, 1'b1);

    // SHR C=2 with serial_l_i=1 on 0x90, then back-to-back HOLD run
    load = 1'b1; par_in = 8'h90; tick(); load = 1'b0;
    mode = 3'd2; count = 4'd2; sl_in = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); chk_state("shr_c1", 8'hC8, 1'b1, 1'b0);
    tick(); chk_state("shr_c2", 8'hE4, 1'b0, 1'b1);
    sl_in = 1'b0;
    mode = 3'd0; count = 4'd1; start = 1'b1; tick(); start = 1'b0;
    chk_state("b2b_start", 8'hE4, 1'b1, 1'b0);
    tick(); chk_state("b2b_done", 8'hE4, 1'b0, 1'b1);

    // SHL C=8 filling ones from 0x00
    load = 1'b1; par_in = 8'h00; tick(); load = 1'b0;
    mode = 3'd1; count = 4'd8; sr_in = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk_state("shl8_c7", 8'h7F, 1'b1, 1'b0);
    tick(); chk_state("shl8_c8", 8'hFF, 1'b0, 1'b1);

    // Same run aborted after the third shift
    load = 1'b1; par_in = 8'h00; tick(); load = 1'b0;
    mode = 3'd1; count = 4'd8; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk_state("abort_pre", 8'h07, 1'b1, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_state("abort", 8'h07, 1'b0, 1'b0);
    tick(); chk_state("abort_after", 8'h07, 1'b0, 1'b0);
    sr_in = 1'b0;

    // C=0 start together with abort in IDLE: done next cycle, never busy
    mode = 3'd1; count = 4'd0; start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    chk_state("c0_start", 8'h07, 1'b0, 1'b1);
    tick(); chk_state("c0_after", 8'h07, 1'b0, 1'b0);

    // Reserved mode 6 run: two busy cycles, value unchanged
    mode = 3'd6; count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    chk_state("rsv_c0", 8'h07, 1'b1, 1'b0);
    tick(); chk_state("rsv_c1", 8'h07, 1'b1, 1'b0);
    tick(); chk_state("rsv_c2", 8'h07, 1'b0, 1'b1);
    chk("ser_l", 32'(sl_out), 32'd0);
    chk("ser_r", 32'(sr_out), 32'd1);

    // STEP=4: ROR C=1 on 0x3C
    load4 = 1'b1; par_in4 = 8'h3C; tick(); load4 = 1'b0;
    chk("s4_load", 32'(par_out4), 32'h3C);
    mode4 = 3'd5; count4 = 4'd1; start4 = 1'b1; tick(); start4 = 1'b0;
    chk("s4_busy", 32'(busy4), 32'd1);
    tick();
    chk("s4_ror", 32'(par_out4), 32'hC3);
    chk("s4_done", 32'(done4), 32'd1);
    chk("s4_sl", 32'(sl_out4), 32'hC);
    chk("s4_sr", 32'(sr_out4), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_univ_shift_reg
`default_nettype wire
